vga_line_fetcher: RTL and testbench



---
 rtl/vga_line_fetcher.sv | 188 ++++++++++++++++++
 tb/tb_vga_line_fetcher.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/vga_line_fetcher.sv
// vga_line_fetcher: streams one scanline of byte pixels from main memory into
// a line buffer and serves the completed line to the pixel pipeline.
// Optional feature macro: VGA_FETCH_DOUBLE_BUF_EN (ping-pong line buffers).
module vga_line_fetcher #(
  parameter int unsigned FB_BASE    = 0,
  parameter int unsigned LINE_BYTES = 640,
  parameter int unsigned LINES      = 480,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        line_req,
  input  logic [9:0]  line_num,
  input  logic        line_swap,
  output logic        intr,
  output logic [31:0] MMemory_VGA_raddr,
  input  logic [7:0]  MMemory_rdata,
  input  logic [9:0]  pix_x,
  output logic [7:0]  pix_data,
  output logic        fetch_busy,
  output logic        fetch_done,
  output logic        overrun
);

  localparam int unsigned IDX_W = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
  localparam int unsigned DRN_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [31:0]         base_q, base_d;
  logic [31:0]         raddr_q, raddr_d;
  logic [IDX_W-1:0]    k_q, k_d;
  logic [DRN_W-1:0]    drn_q, drn_d;
  logic                intr_q, intr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                overrun_q, overrun_d;
  logic [7:0]          pix_data_q, pix_data_d;
  logic [RD_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [IDX_W-1:0]    pipe_idx_q [RD_LATENCY];
  logic [IDX_W-1:0]    pipe_idx_d [RD_LATENCY];
  logic                wr_en_c;
  logic [IDX_W-1:0]    wr_idx_c;

`ifdef VGA_FETCH_DOUBLE_BUF_EN
  logic                front_q, front_d;
  logic                target_q, target_d;
  logic [7:0]          lbuf_q [2][LINE_BYTES];
`else
  logic                unused_swap_c;
  logic [7:0]          lbuf_q [LINE_BYTES];
  assign unused_swap_c = line_swap;
`endif

  // Next-state, address generation, capture pipeline and read port
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    raddr_d    = raddr_q;
    k_d        = k_q;
    drn_d      = drn_q;
    overrun_d  = overrun_q;
    pix_data_d = 8'h00;
`ifdef VGA_FETCH_DOUBLE_BUF_EN
    front_d    = front_q;
    target_d   = target_q;
    // Swap applies before a same-cycle request so the target is the old front
    if (line_swap) begin
      front_d = ~front_q;
      if (state_q != S_IDLE) overrun_d = 1'b1;
    end
`endif
    if (line_req && (state_q != S_IDLE)) overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (line_req && (32'(line_num) < 32'(LINES))) begin
          base_d  = 32'(FB_BASE) + 32'(line_num) * 32'(LINE_BYTES);
          raddr_d = base_d;
          k_d     = '0;
`ifdef VGA_FETCH_DOUBLE_BUF_EN
          target_d = ~front_d;
`endif
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (k_q == IDX_W'(LINE_BYTES - 1)) begin
          drn_d   = '0;
          state_d = S_DRAIN;
        end else begin
          k_d     = k_q + IDX_W'(1);
          raddr_d = base_q + 32'(k_q) + 32'd1;
        end
      end
      S_DRAIN: begin
        if (drn_q == DRN_W'(RD_LATENCY - 1)) state_d = S_DONE;
        else                                  drn_d   = drn_q + DRN_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    intr_d = (state_d == S_ISSUE);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);

    // Stage 0 holds the offset currently on the address port
    pipe_vld_d[0] = (state_q == S_ISSUE);
    pipe_idx_d[0] = k_q;
    for (int i = 1; i < int'(RD_LATENCY); i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_idx_d[i] = pipe_idx_q[i-1];
    end

    if (32'(pix_x) < 32'(LINE_BYTES)) begin
`ifdef VGA_FETCH_DOUBLE_BUF_EN
      pix_data_d = lbuf_q[front_q][IDX_W'(pix_x)];
`else
      pix_data_d = lbuf_q[IDX_W'(pix_x)];
`endif
    end
  end

  assign wr_en_c  = pipe_vld_q[RD_LATENCY-1];
  assign wr_idx_c = pipe_idx_q[RD_LATENCY-1];

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      raddr_q    <= '0;
      k_q        <= '0;
      drn_q      <= '0;
      intr_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      pix_data_q <= 8'h00;
      pipe_vld_q <= '0;
`ifdef VGA_FETCH_DOUBLE_BUF_EN
      front_q    <= 1'b0;
      target_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      raddr_q    <= raddr_d;
      k_q        <= k_d;
      drn_q      <= drn_d;
      intr_q     <= intr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
      pix_data_q <= pix_data_d;
      pipe_vld_q <= pipe_vld_d;
`ifdef VGA_FETCH_DOUBLE_BUF_EN
      front_q    <= front_d;
      target_q   <= target_d;
`endif
    end
  end

  // Offset tags need no reset; their valid bits gate every write
  always_ff @(posedge clk) begin
    pipe_idx_q <= pipe_idx_d;
  end

  // Line buffer write; captures in flight are dropped at reset
  always_ff @(posedge clk) begin
    if (!rst && wr_en_c) begin
`ifdef VGA_FETCH_DOUBLE_BUF_EN
      lbuf_q[target_q][wr_idx_c] <= MMemory_rdata;
`else
      lbuf_q[wr_idx_c] <= MMemory_rdata;
`endif
    end
  end

  assign intr              = intr_q;
  assign MMemory_VGA_raddr = raddr_q;
  assign pix_data          = pix_data_q;
  assign fetch_busy        = busy_q;
  assign fetch_done        = done_q;
  assign overrun           = overrun_q;

endmodule

// File: tb/tb_vga_line_fetcher.sv
// Directed self-checking bench for vga_line_fetcher (8-byte lines, 4 lines,
// base 0x100, read latency 2, memory returns address[7:0]).
module tb_vga_line_fetcher;

  localparam int unsigned LB = 8;
  localparam int unsigned NL = 4;
  localparam int unsigned RL = 2;
  localparam logic [31:0] FB = 32'h100;

  logic        clk;
  logic        rst;
  logic        line_req;
  logic [9:0]  line_num;
  logic        line_swap;
  logic        intr;
  logic [31:0] raddr;
  logic [7:0]  rdata;
  logic [9:0]  pix_x;
  logic [7:0]  pix_data;
  logic        fetch_busy;
  logic        fetch_done;
  logic        overrun;
  logic [31:0] mem_a1;

  int n_checks = 0;
  int n_fail   = 0;

  vga_line_fetcher #(
    .FB_BASE(FB), .LINE_BYTES(LB), .LINES(NL), .RD_LATENCY(RL)
  ) dut (
    .clk(clk), .rst(rst), .line_req(line_req), .line_num(line_num),
    .line_swap(line_swap), .intr(intr), .MMemory_VGA_raddr(raddr),
    .MMemory_rdata(rdata), .pix_x(pix_x), .pix_data(pix_data),
    .fetch_busy(fetch_busy), .fetch_done(fetch_done), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory manager model: address register then RAM, data = address[7:0]
  always_ff @(posedge clk) begin
    mem_a1 <= raddr;
    rdata  <= mem_a1[7:0];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_swap();
    line_swap = 1'b1;
    step();
    line_swap = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic read_pix(input logic [9:0] x, input logic [7:0] exp);
    pix_x = x;
    @(posedge clk);
    @(negedge clk);
    check_eq("pix_data", 32'(pix_data), 32'(exp));
  endtask

  task automatic read_line(input logic [7:0] first);
    for (int x = 0; x < int'(LB); x++) read_pix(10'(x), first + 8'(x));
  endtask

  // Issue a request at edge 0, then watch cycles 1..12; optional extra
  // request, swap or reset pulse in a given cycle (0 = none)
  task automatic run_fetch(input logic [9:0] ln, input bit vld, input int req2,
                           input int swp, input int rcyc);
    logic [31:0] base;
    int hi;
    hi   = 0;
    base = FB + 32'(ln) * 32'(LB);
    line_num = ln;
    line_req = 1'b1;
    step();
    line_req = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      line_req  = (c == req2);
      line_swap = (c == swp);
      rst       = (c == rcyc);
      @(negedge clk);
      if (intr) hi++;
      if (rcyc != 0 && c > rcyc) begin
        check_eq("rst_intr",  32'(intr), 32'd0);
        check_eq("rst_busy",  32'(fetch_busy), 32'd0);
        check_eq("rst_done",  32'(fetch_done), 32'd0);
        check_eq("rst_raddr", raddr, 32'd0);
      end else if (!vld) begin
        check_eq("inv_intr", 32'(intr), 32'd0);
        check_eq("inv_busy", 32'(fetch_busy), 32'd0);
        check_eq("inv_done", 32'(fetch_done), 32'd0);
      end else begin
        check_eq("intr",  32'(intr), 32'(c <= int'(LB)));
        check_eq("raddr", raddr, (c <= int'(LB)) ? base + 32'(c) - 32'd1 : base + 32'(LB) - 32'd1);
        check_eq("done",  32'(fetch_done), 32'(c == int'(LB + RL + 1)));
        check_eq("busy",  32'(fetch_busy), 32'(c <= int'(LB + RL + 1)));
      end
      step();
    end
    line_req  = 1'b0;
    line_swap = 1'b0;
    rst       = 1'b0;
    check_eq("intr_len", 32'(hi), (rcyc != 0) ? 32'(rcyc) : (vld ? 32'(LB) : 32'd0));
  endtask

  initial begin
    rst = 1'b1; line_req = 1'b0; line_num = '0; line_swap = 1'b0; pix_x = '0;
    repeat (3) step();
    @(negedge clk);
    check_eq("reset_intr",  32'(intr), 32'd0);
    check_eq("reset_raddr", raddr, 32'd0);
    check_eq("reset_busy",  32'(fetch_busy), 32'd0);
    check_eq("reset_done",  32'(fetch_done), 32'd0);
    check_eq("reset_ovr",   32'(overrun), 32'd0);
    check_eq("reset_pix",   32'(pix_data), 32'd0);
    rst = 1'b0;
    step();

    // Basic fetch of line 2, then present it
    run_fetch(10'd2, 1'b1, 0, 0, 0);
    do_swap();
    read_line(8'h10);
    read_pix(10'd9, 8'h00);

    // Out-of-range line is ignored
    run_fetch(10'd4, 1'b0, 0, 0, 0);
    check_eq("inv_ovr", 32'(overrun), 32'd0);

    // Request while busy is dropped and flagged until reset
    run_fetch(10'd1, 1'b1, 5, 0, 0);
    check_eq("ovr_set", 32'(overrun), 32'd1);
    repeat (4) step();
    check_eq("ovr_sticky", 32'(overrun), 32'd1);
    pulse_rst();
    @(negedge clk);
    check_eq("ovr_clr", 32'(overrun), 32'd0);

`ifdef VGA_FETCH_DOUBLE_BUF_EN
    // Ping-pong: back-buffer fill is invisible until swapped
    run_fetch(10'd0, 1'b1, 0, 0, 0);
    do_swap();
    run_fetch(10'd1, 1'b1, 0, 0, 0);
    read_pix(10'd3, 8'h03);
    do_swap();
    read_pix(10'd3, 8'h0B);
    check_eq("pp_ovr_clean", 32'(overrun), 32'd0);
    run_fetch(10'd2, 1'b1, 0, 5, 0);
    check_eq("pp_ovr_tear", 32'(overrun), 32'd1);
    read_pix(10'd3, 8'h13);
`else
    // Single buffer: data visible right after completion, swap is inert
    run_fetch(10'd0, 1'b1, 0, 0, 0);
    read_pix(10'd3, 8'h03);
    run_fetch(10'd1, 1'b1, 0, 5, 0);
    check_eq("sb_ovr_swap", 32'(overrun), 32'd0);
    read_pix(10'd3, 8'h0B);
    run_fetch(10'd3, 1'b1, 0, 0, 0);
    read_pix(10'd3, 8'h1B);
`endif

    // Reset mid-fetch, then a clean fetch
    pulse_rst();
    run_fetch(10'd1, 1'b1, 0, 0, 4);
    check_eq("mrst_ovr", 32'(overrun), 32'd0);
    run_fetch(10'd3, 1'b1, 0, 0, 0);
    do_swap();
    read_line(8'h18);
    read_pix(10'd9, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
